alu_seq: RTL

- Parametrised-width successor to the team's 32-bit ALU.
- Single-cycle logic and arithmetic ops are registered with 1-cycle latency.
- Unsigned DIV/MOD are multi-cycle, using an iterative restoring divider.
- A valid/ready handshake on the input and a status flag set on the output let the block sit behind a simple datapath controller.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_divider.sv | 67 ++++++
 rtl/alu_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode values and FSM state encoding for the sequential ALU.
package alu_pkg;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NOR  = 3;
    localparam int OP_SLT  = 4;
    localparam int OP_ADD  = 5;
    localparam int OP_SUB  = 6;
    localparam int OP_MOD  = 7;
    localparam int OP_DIV  = 8;
    localparam int OP_SLTU = 9;
    localparam int OP_SLL  = 10;
    localparam int OP_SRL  = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] prem, quo, dsr;
    logic [CNT_W-1:0] cnt;
    logic             run;

    // Shift in the next dividend bit, trial-subtract on a WIDTH+1 bit
    // partial remainder, restore when negative. Returns {rem, quo}.
    function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] d);
        logic [WIDTH:0] t;
        logic           ge;
        t  = {r, q[WIDTH-1]};
        ge = (t >= {1'b0, d});
        if (ge) t = t - {1'b0, d};
        return {t[WIDTH-1:0], q[WIDTH-2:0], ge};
    endfunction

    // The first iteration runs on the start edge so the final bit lands
    // WIDTH-1 edges later and done is seen by the FSM on edge WIDTH.
    always_ff @(posedge CLK) begin
        if (reset) begin
            prem <= '0;
            quo  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {prem, quo} <= step('0, dividend, divisor);
                dsr         <= divisor;
                cnt         <= CNT_W'(1);
                run         <= 1'b1;
            end else if (run) begin
                {prem, quo} <= step(prem, quo, dsr);
                cnt         <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign busy      = run;
    assign quotient  = quo;
    assign remainder = prem;

endmodule

// File: rtl/alu_seq.sv
// Parametrised ALU: registered single-cycle ops plus a multi-cycle unsigned
// DIV/MOD path behind a valid/ready request handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             dbz,
    output logic             illegal
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic             accept, is_div_op, div_start, div_busy, div_done, mod_q;
    logic [WIDTH-1:0] quo, rem, div_res;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH:0]   sum;
    logic             cout_nxt, ovf_nxt, dbz_nxt, ill_nxt, slt, sltu;

    assign accept    = in_valid && in_ready;
    assign is_div_op = (alu_op == OP_W'(OP_DIV)) || (alu_op == OP_W'(OP_MOD));
    assign slt       = $signed(ain) < $signed(bin);
    assign sltu      = ain < bin;
    assign div_res   = mod_q ? rem : quo;

    always_ff @(posedge CLK) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (div_start) state_nxt = S_DIV;
            S_DIV:   if (div_done)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && !div_busy;
        div_start = (state == S_IDLE) && accept && is_div_op && (bin != '0);
    end

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .CLK       (CLK),
        .reset     (reset),
        .start     (div_start),
        .dividend  (ain),
        .divisor   (bin),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    // Single-cycle results; DIV/MOD entries here cover only the b==0 case.
    always_comb begin
        r_nxt    = '0;
        sum      = '0;
        cout_nxt = 1'b0;
        ovf_nxt  = 1'b0;
        dbz_nxt  = 1'b0;
        ill_nxt  = 1'b0;
        case (alu_op)
            OP_W'(OP_AND):  r_nxt = ain & bin;
            OP_W'(OP_OR):   r_nxt = ain | bin;
            OP_W'(OP_XOR):  r_nxt = ain ^ bin;
            OP_W'(OP_NOR):  r_nxt = ~(ain | bin);
            OP_W'(OP_SLT):  r_nxt = {{(WIDTH-1){1'b0}}, slt};
            OP_W'(OP_SLTU): r_nxt = {{(WIDTH-1){1'b0}}, sltu};
            OP_W'(OP_ADD): begin
                sum      = {1'b0, ain} + {1'b0, bin} + {{WIDTH{1'b0}}, cin};
                r_nxt    = sum[WIDTH-1:0];
                cout_nxt = sum[WIDTH];
                ovf_nxt  = (ain[WIDTH-1] == bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]);
            end
            OP_W'(OP_SUB): begin
                sum      = {1'b0, ain} + {1'b0, ~bin} + (WIDTH+1)'(1);
                r_nxt    = sum[WIDTH-1:0];
                cout_nxt = sum[WIDTH];
                ovf_nxt  = (ain[WIDTH-1] != bin[WIDTH-1]) && (sum[WIDTH-1] != ain[WIDTH-1]);
            end
            OP_W'(OP_MOD): begin
                r_nxt   = ain;
                dbz_nxt = 1'b1;
            end
            OP_W'(OP_DIV): begin
                r_nxt   = '1;
                dbz_nxt = 1'b1;
            end
            OP_W'(OP_SLL):  r_nxt = ain << bin[SH_W-1:0];
            OP_W'(OP_SRL):  r_nxt = ain >> bin[SH_W-1:0];
            default:        ill_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            dbz       <= 1'b0;
            illegal   <= 1'b0;
            mod_q     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (div_start) mod_q <= (alu_op == OP_W'(OP_MOD));
            if ((state == S_DIV) && div_done) begin
                out_valid <= 1'b1;
                result    <= div_res;
                zero      <= (div_res == '0);
                cout      <= 1'b0;
                ovf       <= 1'b0;
                dbz       <= 1'b0;
                illegal   <= 1'b0;
            end else if (accept && !div_start) begin
                out_valid <= 1'b1;
                result    <= r_nxt;
                zero      <= (r_nxt == '0);
                cout      <= cout_nxt;
                ovf       <= ovf_nxt;
                dbz       <= dbz_nxt;
                illegal   <= ill_nxt;
            end
        end
    end

endmodule
